forth_cpu_core: RTL and testbench
=================================

# forth_cpu_core

16-bit load/store processor core for the ForthCPU system: fetches 16-bit instructions from a shared word-wide memory bus, executes ALU, load/store, jump and control operations over a 16-entry register file, and exposes phase status, two interrupt inputs and an 8-bit debug port. It sits between the top-level bus buffers/memory and the debugger UART bridge.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STOPPED  out  1  core halted (HALT instruction or debug halt).
- FETCH / DECODE / EXECUTE / COMMIT  out  1 each  one-hot phase indicators.
- INT0, INT1  in  1  level-sensitive interrupt requests; INT0 has priority.
- ADDR_BUF  out  16  byte address.
- DOUT_BUF  out  16  write data.
- DIN  in  16  read data, sampled at the end of a read cycle.
- RDN_BUF  out  1  active-low read strobe.
- WRN0_BUF / WRN1_BUF  out  1  active-low write strobes, low / high byte.
- ABUS_OEN  out  1  active-low bus output enable; high while STOPPED.
- DEBUG_DIN  in  8, DEBUG_DOUT  out  8, DEBUG_ADDR  in  3, DEBUG_RD / DEBUG_WR  in  1  debug register port.

## Operation
- Registers: 16×16-bit, indices 0–12 = R0–R12, 13 = RA (accumulator), 14 = RL (link), 15 = R15. PC is a byte address, even. Flags: Z (result==0), C (borrow on SUB/CMP, carry on ADD), S (result[15]), P (result[0]).
- Encoding: [15:14] group: 00 control, 01 load/store, 10 ALU, 11 jump.
- Control: 0x0000 NOP, 0x0001 HALT, 0x0002 EI, 0x0003 DI. Other codes execute as NOP.
- ALU: [13:10] op: 0 MOV, 1 ADD, 2 SUB, 3 CMP, 4 AND, 5 OR, 6 XOR, 7 NOT; others execute as NOP.
- ALU mode field [9:8]:
  - 0 reg-reg: Rd=[7:4], Rs=[3:0].
  - 1 reg-U4: Rd=[7:4], operand = zero-extended [3:0].
  - 2 RA-U8: zero-extended [7:0].
  - 3 RA-S8: sign-extended [7:0].
- ALU results: the result is written to Rd except for CMP, which only updates flags. Flags update on ADD/SUB/CMP/logic ops; MOV leaves flags unchanged.
- Load/store: [13] = 0, [12] op: 0 LD, 1 ST. [11:8] mode: 0 reg-reg, 1 immediate (LD only). [7:4] Rd/Rs, [3:0] address register Rb.
  - ST: mem[Rb] ← Rs.
  - LD reg-reg: Rd ← mem[Rb].
  - LD immediate (LDI): Rd ← the word at PC+2; instruction length is 4 bytes.
- Jump: [13] mode: 0 immediate, target = word at PC+2, length 4; 1 register, target = R[3:0], length 2.
  - [12] invert condition.
  - [11:10] condition select: 0 Z, 1 C, 2 S, 3 P.
  - [9] unconditional.
  - [8] link: RL ← return address.
  - Taken: PC ← target. Not taken: PC ← PC+length.
- Interrupts: checked at the end of COMMIT when IE=1. RL ← next PC, IE ← 0, PC ← 0x0100 (INT0) or 0x0104 (INT1). A simultaneous INT0 and INT1 selects INT0.
- Debug port, registered access:
  - Address 0: write bit0 = halt, bit1 = single-step one instruction, bit2 = resume. Read = {5'b0, IE, STOPPED, phase==FETCH}.
  - Addresses 1/2: PC low/high (read).
  - Address 3: register select (write/read).
  - Addresses 4/5: selected register low/high (read).
  - Addresses 6/7: read 0.
  - DEBUG_DOUT is valid the cycle after DEBUG_RD.

## Timing
- Reset values: PC=0, all registers 0, flags 0, IE=0. FETCH=1, other phase outputs 0. STOPPED=0, RDN=WRN0=WRN1=1, ABUS_OEN=0, ADDR_BUF=0, DOUT_BUF=0, DEBUG_DOUT=0.
- Each instruction takes four cycles: FETCH → DECODE → EXECUTE → COMMIT → FETCH.
- FETCH: ADDR_BUF=PC, RDN low, IR ← DIN.
- EXECUTE: for LDI or immediate jump, ADDR=PC+2 with RDN low; for LD, ADDR=Rb with RDN low.
- Stores: ADDR=Rb and DOUT=Rs are driven in EXECUTE and COMMIT; WRN0 and WRN1 are both low in COMMIT only.
- Register, flag and PC writes happen at the end of COMMIT.
- HALT or debug halt: the core stops after COMMIT. While stopped, phase outputs are all 0, STOPPED=1 and ABUS_OEN=1. Resume restarts at FETCH.
- RESET asserted mid-instruction aborts the instruction and no write completes.

## Test plan
- LDI 0xfaaf→R0, then MOV RA,S8 0xaf, then ST RA,(R0) → write cycle at 0xfaaf with data 0xffaf and both WRN low.
- MOV R1..R4 with U4 values 1,3,5,7, each stored via R0 → data 0x0001, 0x0003, 0x0005, 0x0007.
- RA=0x4444; ADD RA,S8 0x82 → 0x43c6. RA=0x4444; ADD RA,U8 0x22 → 0x4466. R0=0x4444; ADD R0,U4 5 → 0x4449.
- RA=0x1110, R1=0x1111; SUB RA,R1 → RA=0xffff; JPI on Z not taken; JPI on C, S and P each taken to 0x3333.
- RA=R1=0x1111; CMP RA,R1 → RA unchanged at 0x1111; JPI on Z taken; JPI on C, S and P each not taken (PC advances by 4).
- With EI executed, assert INT0 and INT1 together → PC=0x0100, RL=next PC, IE=0. Debug halt → STOPPED=1 and ABUS_OEN=1 after the current COMMIT.

Source files
------------

// File: rtl/forth_cpu_core.sv
// 16-bit load/store core with a four-phase FETCH/DECODE/EXECUTE/COMMIT sequence,
// two level interrupts and a byte-wide debug register port for halt/step/inspect.
module forth_cpu_core (
    input  logic        CLK,
    input  logic        RESET,
    output logic        STOPPED,
    output logic        FETCH,
    output logic        DECODE,
    output logic        EXECUTE,
    output logic        COMMIT,
    input  logic        INT0,
    input  logic        INT1,
    output logic [15:0] ADDR_BUF,
    output logic [15:0] DOUT_BUF,
    input  logic [15:0] DIN,
    output logic        RDN_BUF,
    output logic        WRN0_BUF,
    output logic        WRN1_BUF,
    output logic        ABUS_OEN,
    input  logic [7:0]  DEBUG_DIN,
    output logic [7:0]  DEBUG_DOUT,
    input  logic [2:0]  DEBUG_ADDR,
    input  logic        DEBUG_RD,
    input  logic        DEBUG_WR
);

    typedef enum logic [2:0] {PH_FETCH, PH_DECODE, PH_EXECUTE, PH_COMMIT, PH_STOP} phase_t;

    phase_t      phase, phase_next;
    logic [15:0] regs [16];
    logic [15:0] pc, ir, mem_data;
    logic        flag_z, flag_c, flag_s, flag_p, ie, halt_req;
    logic [7:0]  dbg_sel;

    logic [3:0]  alu_op, alu_rd;
    logic [1:0]  alu_mode;
    logic [15:0] op_a, op_b, alu_res, pc_seq, pc_commit;
    logic [16:0] alu_wide;
    logic        is_alu, alu_writes, alu_flags;
    logic        is_ls, is_ld_reg, is_ldi, is_st, is_jmp, jmp_imm, cond_flag, jmp_taken;
    logic        is_halt, is_ei, is_di, needs_ext, bus_rd, bus_wr, int_take, dbg_ctrl_wr;

    // Instruction decode, ALU datapath and next-PC selection.
    always_comb begin
        alu_op    = ir[13:10];
        alu_mode  = ir[9:8];
        is_alu    = (ir[15:14] == 2'b10) && (alu_op <= 4'd7);
        alu_rd    = alu_mode[1] ? 4'd13 : ir[7:4];
        op_a      = regs[alu_rd];
        case (alu_mode)
            2'd0:    op_b = regs[ir[3:0]];
            2'd1:    op_b = {12'b0, ir[3:0]};
            2'd2:    op_b = {8'b0, ir[7:0]};
            default: op_b = {{8{ir[7]}}, ir[7:0]};
        endcase
        case (alu_op)
            4'd0:        alu_wide = {1'b0, op_b};
            4'd1:        alu_wide = {1'b0, op_a} + {1'b0, op_b};
            4'd2, 4'd3:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
            4'd4:        alu_wide = {1'b0, op_a & op_b};
            4'd5:        alu_wide = {1'b0, op_a | op_b};
            4'd6:        alu_wide = {1'b0, op_a ^ op_b};
            4'd7:        alu_wide = {1'b0, ~op_b};
            default:     alu_wide = {1'b0, op_a};
        endcase
        alu_res    = alu_wide[15:0];
        alu_writes = is_alu && (alu_op != 4'd3);
        alu_flags  = is_alu && (alu_op != 4'd0);

        is_ls     = (ir[15:13] == 3'b010);
        is_ld_reg = is_ls && (ir[12:8] == 5'b00000);
        is_ldi    = is_ls && (ir[12:8] == 5'b00001);
        is_st     = is_ls && (ir[12:8] == 5'b10000);
        is_halt   = (ir == 16'h0001);
        is_ei     = (ir == 16'h0002);
        is_di     = (ir == 16'h0003);

        is_jmp  = (ir[15:14] == 2'b11);
        jmp_imm = !ir[13];
        case (ir[11:10])
            2'd0:    cond_flag = flag_z;
            2'd1:    cond_flag = flag_c;
            2'd2:    cond_flag = flag_s;
            default: cond_flag = flag_p;
        endcase
        jmp_taken = ir[9] | (cond_flag ^ ir[12]);

        needs_ext = is_ldi || (is_jmp && jmp_imm);
        pc_seq    = pc + (needs_ext ? 16'd4 : 16'd2);
        if (is_jmp && jmp_taken)
            pc_commit = jmp_imm ? mem_data : regs[ir[3:0]];
        else
            pc_commit = pc_seq;

        int_take    = ie && (INT0 || INT1);
        dbg_ctrl_wr = DEBUG_WR && (DEBUG_ADDR == 3'd0);
    end

    // Bus strobes are forced inactive during reset so an aborted store never lands.
    always_comb begin
        bus_rd   = (phase == PH_FETCH) || ((phase == PH_EXECUTE) && (needs_ext || is_ld_reg));
        bus_wr   = (phase == PH_COMMIT) && is_st;
        ADDR_BUF = pc;
        DOUT_BUF = '0;
        if (phase == PH_EXECUTE && needs_ext)
            ADDR_BUF = pc + 16'd2;
        else if ((phase == PH_EXECUTE && (is_ld_reg || is_st)) || bus_wr)
            ADDR_BUF = regs[ir[3:0]];
        if ((phase == PH_EXECUTE || phase == PH_COMMIT) && is_st)
            DOUT_BUF = regs[ir[7:4]];
        RDN_BUF  = !(bus_rd && !RESET);
        WRN0_BUF = !(bus_wr && !RESET);
        WRN1_BUF = !(bus_wr && !RESET);
        ABUS_OEN = (phase == PH_STOP);
        STOPPED  = (phase == PH_STOP);
        FETCH    = (phase == PH_FETCH);
        DECODE   = (phase == PH_DECODE);
        EXECUTE  = (phase == PH_EXECUTE);
        COMMIT   = (phase == PH_COMMIT);
    end

    always_comb begin
        phase_next = phase;
        case (phase)
            PH_FETCH:   phase_next = PH_DECODE;
            PH_DECODE:  phase_next = PH_EXECUTE;
            PH_EXECUTE: phase_next = PH_COMMIT;
            PH_COMMIT:  phase_next = (is_halt || halt_req) ? PH_STOP : PH_FETCH;
            PH_STOP:    if (dbg_ctrl_wr && (DEBUG_DIN[1] || DEBUG_DIN[2])) phase_next = PH_FETCH;
            default:    phase_next = PH_FETCH;
        endcase
    end

    // Architectural state; everything lands at the end of COMMIT, interrupts last.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase    <= PH_FETCH;
            pc       <= '0;
            ir       <= '0;
            mem_data <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_s   <= 1'b0;
            flag_p   <= 1'b0;
            ie       <= 1'b0;
            halt_req <= 1'b0;
            dbg_sel  <= '0;
            DEBUG_DOUT <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            phase <= phase_next;
            case (phase)
                PH_FETCH:   ir <= DIN;
                PH_EXECUTE: if (needs_ext || is_ld_reg) mem_data <= DIN;
                PH_COMMIT: begin
                    if (alu_writes) regs[alu_rd] <= alu_res;
                    if (alu_flags) begin
                        flag_z <= (alu_res == 16'h0000);
                        flag_c <= alu_wide[16];
                        flag_s <= alu_res[15];
                        flag_p <= alu_res[0];
                    end
                    if (is_ld_reg || is_ldi) regs[ir[7:4]] <= mem_data;
                    if (is_jmp && ir[8]) regs[14] <= pc_seq;
                    if (is_ei) ie <= 1'b1;
                    if (is_di) ie <= 1'b0;
                    pc <= pc_commit;
                    if (int_take) begin
                        regs[14] <= pc_commit;
                        ie       <= 1'b0;
                        pc       <= INT0 ? 16'h0100 : 16'h0104;
                    end
                end
                default: ;
            endcase

            // Halt requests are consumed on stopping; a step re-arms one for the next COMMIT.
            if (phase == PH_STOP) begin
                if (dbg_ctrl_wr) halt_req <= DEBUG_DIN[1] & ~DEBUG_DIN[2];
            end else if (phase == PH_COMMIT && phase_next == PH_STOP) begin
                halt_req <= 1'b0;
            end else if (dbg_ctrl_wr && DEBUG_DIN[0]) begin
                halt_req <= 1'b1;
            end

            if (DEBUG_WR && DEBUG_ADDR == 3'd3) dbg_sel <= DEBUG_DIN;
            if (DEBUG_RD) begin
                case (DEBUG_ADDR)
                    3'd0:    DEBUG_DOUT <= {5'b0, ie, phase == PH_STOP, phase == PH_FETCH};
                    3'd1:    DEBUG_DOUT <= pc[7:0];
                    3'd2:    DEBUG_DOUT <= pc[15:8];
                    3'd3:    DEBUG_DOUT <= dbg_sel;
                    3'd4:    DEBUG_DOUT <= regs[dbg_sel[3:0]][7:0];
                    3'd5:    DEBUG_DOUT <= regs[dbg_sel[3:0]][15:8];
                    default: DEBUG_DOUT <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_forth_cpu_core.sv
// Directed bench for forth_cpu_core: runs a hand-assembled program from a word
// memory model and checks bus cycles, branch targets, interrupts and the debug port.
module tb_forth_cpu_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STOPPED, FETCH, DECODE, EXECUTE, COMMIT;
    logic        INT0 = 1'b0, INT1 = 1'b0;
    logic [15:0] ADDR_BUF, DOUT_BUF, DIN;
    logic        RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN;
    logic [7:0]  DEBUG_DIN = '0, DEBUG_DOUT;
    logic [2:0]  DEBUG_ADDR = '0;
    logic        DEBUG_RD = 1'b0, DEBUG_WR = 1'b0;

    logic [15:0] mem [0:32767];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] fa;
    logic [7:0]  dd;

    forth_cpu_core dut (
        .CLK(CLK), .RESET(RESET), .STOPPED(STOPPED), .FETCH(FETCH), .DECODE(DECODE),
        .EXECUTE(EXECUTE), .COMMIT(COMMIT), .INT0(INT0), .INT1(INT1),
        .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF), .DIN(DIN), .RDN_BUF(RDN_BUF),
        .WRN0_BUF(WRN0_BUF), .WRN1_BUF(WRN1_BUF), .ABUS_OEN(ABUS_OEN),
        .DEBUG_DIN(DEBUG_DIN), .DEBUG_DOUT(DEBUG_DOUT), .DEBUG_ADDR(DEBUG_ADDR),
        .DEBUG_RD(DEBUG_RD), .DEBUG_WR(DEBUG_WR)
    );

    always #5 CLK = ~CLK;

    assign DIN = mem[ADDR_BUF[15:1]];

    // Word writes are only logged; the program never reads back what it stores.
    always @(posedge CLK) begin
        if (!RESET && !WRN0_BUF && !WRN1_BUF) begin
            wr_addr_q.push_back(ADDR_BUF);
            wr_data_q.push_back(DOUT_BUF);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] addr, input logic [15:0] val);
        mem[addr[15:1]] = val;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic run_to(input logic [15:0] addr, input string tag);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(FETCH && ADDR_BUF == addr) && n < 300);
        if (n >= 300) check({tag, "_timeout"}, ADDR_BUF, addr);
    endtask

    task automatic expect_fetch(input logic [15:0] exp, input string tag);
        int n = 0;
        while (FETCH && n < 40) begin @(negedge CLK); n++; end
        while (!FETCH && n < 40) begin @(negedge CLK); n++; end
        check(tag, (n >= 40) ? 16'hdead : ADDR_BUF, exp);
    endtask

    task automatic wait_stopped(input string tag);
        int n = 0;
        while (!STOPPED && n < 100) begin @(negedge CLK); n++; end
        check(tag, {15'b0, STOPPED}, 16'h0001);
    endtask

    task automatic dbg_write(input logic [2:0] a, input logic [7:0] d);
        DEBUG_ADDR = a;
        DEBUG_DIN  = d;
        DEBUG_WR   = 1'b1;
        @(negedge CLK);
        DEBUG_WR   = 1'b0;
    endtask

    task automatic dbg_read(input logic [2:0] a, output logic [7:0] d);
        DEBUG_ADDR = a;
        DEBUG_RD   = 1'b1;
        @(negedge CLK);
        DEBUG_RD   = 1'b0;
        d = DEBUG_DOUT;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        // stores through R0 = 0xfaaf
        put(16'h00, 16'h4100); put(16'h02, 16'hfaaf); put(16'h04, 16'h83af); put(16'h06, 16'h50d0);
        put(16'h08, 16'h8111); put(16'h0a, 16'h5010); put(16'h0c, 16'h8123); put(16'h0e, 16'h5020);
        put(16'h10, 16'h8135); put(16'h12, 16'h5030); put(16'h14, 16'h8147); put(16'h16, 16'h5040);
        // adds, results stored through R5 = 0x2000
        put(16'h1a, 16'h4150); put(16'h1c, 16'h2000); put(16'h1e, 16'h41d0); put(16'h20, 16'h4444);
        put(16'h22, 16'h8782); put(16'h24, 16'h50d5); put(16'h26, 16'h41d0); put(16'h28, 16'h4444);
        put(16'h2a, 16'h8622); put(16'h2c, 16'h50d5); put(16'h2e, 16'h4100); put(16'h30, 16'h4444);
        put(16'h32, 16'h8505); put(16'h34, 16'h5005);
        // SUB/CMP with conditional jumps; R6..R9 hold return points from 0x3333
        put(16'h36, 16'h41d0); put(16'h38, 16'h1110); put(16'h3a, 16'h4110); put(16'h3c, 16'h1111);
        put(16'h3e, 16'h4160); put(16'h40, 16'h005a); put(16'h42, 16'h4170); put(16'h44, 16'h005e);
        put(16'h46, 16'h4180); put(16'h48, 16'h0062); put(16'h4a, 16'h4190); put(16'h4c, 16'h006e);
        put(16'h4e, 16'h88d1); put(16'h50, 16'h50d5);
        put(16'h52, 16'hc000); put(16'h54, 16'h3333); put(16'h56, 16'hc400); put(16'h58, 16'h3333);
        put(16'h5a, 16'hc800); put(16'h5c, 16'h3333); put(16'h5e, 16'hcc00); put(16'h60, 16'h3333);
        put(16'h62, 16'h41d0); put(16'h64, 16'h1111); put(16'h66, 16'h8cd1); put(16'h68, 16'h50d5);
        put(16'h6a, 16'hc000); put(16'h6c, 16'h3333); put(16'h6e, 16'hc400); put(16'h70, 16'h3333);
        put(16'h72, 16'hc800); put(16'h74, 16'h3333); put(16'h76, 16'hcc00); put(16'h78, 16'h3333);
        put(16'h7a, 16'h0002);
        put(16'h100, 16'h50e5); put(16'h10a, 16'h0001);
        put(16'h3333, 16'he206);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_fetch",   {15'b0, FETCH}, 16'h0001);
        check("rst_phases",  {13'b0, DECODE, EXECUTE, COMMIT}, 16'h0000);
        check("rst_stopped", {15'b0, STOPPED}, 16'h0000);
        check("rst_strobes", {13'b0, RDN_BUF, WRN0_BUF, WRN1_BUF}, 16'h0007);
        check("rst_oen",     {15'b0, ABUS_OEN}, 16'h0000);
        check("rst_addr",    ADDR_BUF, 16'h0000);
        check("rst_dout",    DOUT_BUF, 16'h0000);
        check("rst_dbg",     {8'b0, DEBUG_DOUT}, 16'h0000);
        RESET = 1'b0;

        run_to(16'h0006, "st_ra");
        tick(); tick();
        check("st_ex_addr", ADDR_BUF, 16'hfaaf);
        check("st_ex_data", DOUT_BUF, 16'hffaf);
        check("st_ex_wrn",  {14'b0, WRN0_BUF, WRN1_BUF}, 16'h0003);
        tick();
        check("st_cm_addr", ADDR_BUF, 16'hfaaf);
        check("st_cm_data", DOUT_BUF, 16'hffaf);
        check("st_cm_wrn",  {14'b0, WRN0_BUF, WRN1_BUF}, 16'h0000);

        run_to(16'h001a, "mov_u4");
        check("mov_r1", wr_data_q[1], 16'h0001);
        check("mov_r2", wr_data_q[2], 16'h0003);
        check("mov_r3", wr_data_q[3], 16'h0005);
        check("mov_r4", wr_data_q[4], 16'h0007);

        run_to(16'h0036, "adds");
        check("add_s8",   wr_data_q[5], 16'h43c6);
        check("add_u8",   wr_data_q[6], 16'h4466);
        check("add_u4",   wr_data_q[7], 16'h4449);
        check("add_addr", wr_addr_q[7], 16'h2000);

        run_to(16'h0052, "sub");
        check("sub_res", wr_data_q[8], 16'hffff);
        expect_fetch(16'h0056, "sub_jz_nt");
        expect_fetch(16'h3333, "sub_jc_t");
        @(posedge CLK); #1 put(16'h3333, 16'he207);
        expect_fetch(16'h005a, "ret_r6");
        expect_fetch(16'h3333, "sub_js_t");
        @(posedge CLK); #1 put(16'h3333, 16'he208);
        expect_fetch(16'h005e, "ret_r7");
        expect_fetch(16'h3333, "sub_jp_t");
        @(posedge CLK); #1 put(16'h3333, 16'he209);
        expect_fetch(16'h0062, "ret_r8");

        run_to(16'h006a, "cmp");
        check("cmp_ra", wr_data_q[9], 16'h1111);
        expect_fetch(16'h3333, "cmp_jz_t");
        expect_fetch(16'h006e, "ret_r9");
        expect_fetch(16'h0072, "cmp_jc_nt");
        expect_fetch(16'h0076, "cmp_js_nt");
        expect_fetch(16'h007a, "cmp_jp_nt");

        INT0 = 1'b1;
        INT1 = 1'b1;
        expect_fetch(16'h007c, "ei_next");
        expect_fetch(16'h0100, "int_vec");
        INT0 = 1'b0;
        INT1 = 1'b0;
        expect_fetch(16'h0102, "isr_next");
        check("int_rl", wr_data_q[10], 16'h007e);

        dbg_write(3'd0, 8'h01);
        dbg_read(3'd0, dd);
        check("dbg_stat_run", {8'b0, dd}, 16'h0000);
        tick();
        check("halt_commit", {15'b0, COMMIT}, 16'h0001);
        tick();
        check("halt_stopped", {15'b0, STOPPED}, 16'h0001);
        check("halt_oen",     {15'b0, ABUS_OEN}, 16'h0001);
        check("halt_phases",  {12'b0, FETCH, DECODE, EXECUTE, COMMIT}, 16'h0000);
        dbg_read(3'd1, dd);
        check("halt_pc_lo", {8'b0, dd}, 16'h0004);
        dbg_read(3'd2, dd);
        check("halt_pc_hi", {8'b0, dd}, 16'h0001);
        dbg_read(3'd0, dd);
        check("dbg_stat_stop", {8'b0, dd}, 16'h0002);
        dbg_write(3'd3, 8'd13);
        dbg_read(3'd4, dd);
        check("dbg_ra_lo", {8'b0, dd}, 16'h0011);
        dbg_read(3'd5, dd);
        check("dbg_ra_hi", {8'b0, dd}, 16'h0011);

        dbg_write(3'd0, 8'h02);
        check("step_fetch", {FETCH, ADDR_BUF[14:0]}, 16'h8104);
        wait_stopped("step_stop");
        dbg_read(3'd1, dd);
        check("step_pc_lo", {8'b0, dd}, 16'h0006);

        dbg_write(3'd0, 8'h04);
        check("resume_fetch", {FETCH, ADDR_BUF[14:0]}, 16'h8106);
        wait_stopped("halt_instr");
        dbg_read(3'd1, dd);
        check("hlt_pc_lo", {8'b0, dd}, 16'h000c);
        check("wr_count", 16'(wr_data_q.size()), 16'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
